// File: rtl/spi_slave.sv
// SPI mode-0 MSB-first peripheral: oversamples sclk/cs/mosi in the clk domain, deserialises frames
// and, when SPI_SLAVE_MISO_EN is defined, serialises a buffered response word onto miso.
module spi_slave #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-2:0]  rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_err_q, rx_err_d;
  logic                   busy_q, busy_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DATA_WIDTH-1:0] rx_word;

`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                  miso_q, miso_d;
  logic [DATA_WIDTH-1:0] tx_next;

  // A load in the same cycle as a (re)load bypasses the buffer.
  assign tx_next = tx_load ? tx_data : tx_buf_q;
  assign miso    = miso_q;
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_load};
  assign miso      = 1'b0;
`endif

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign rx_word   = {rx_sh_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    busy_d      = ~cs_s;
`ifdef SPI_SLAVE_MISO_EN
    tx_buf_d    = tx_load ? tx_data : tx_buf_q;
    tx_sh_d     = tx_sh_q;
    miso_d      = miso_q;
`endif

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          cnt_d   = '0;
`ifdef SPI_SLAVE_MISO_EN
          tx_sh_d = tx_next;
          miso_d  = tx_next[DATA_WIDTH-1];
`endif
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d  = IDLE;
          rx_err_d = (cnt_q != '0);
          cnt_d    = '0;
`ifdef SPI_SLAVE_MISO_EN
          miso_d   = 1'b0;
`endif
        end else if (sclk_rise) begin
          rx_sh_d = rx_word[DATA_WIDTH-2:0];
          if (cnt_q == LAST_BIT) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
`ifdef SPI_SLAVE_MISO_EN
            tx_sh_d    = tx_next;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
`ifdef SPI_SLAVE_MISO_EN
          // Counter at zero means a word boundary: present the freshly reloaded MSB unshifted.
          if (cnt_q == '0) begin
            miso_d = tx_sh_q[DATA_WIDTH-1];
          end else begin
            tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
            miso_d  = tx_sh_q[DATA_WIDTH-2];
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
      tx_buf_q    <= '0;
      tx_sh_q     <= '0;
      miso_q      <= 1'b0;
`endif
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      busy_q      <= busy_d;
`ifdef SPI_SLAVE_MISO_EN
      tx_buf_q    <= tx_buf_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
`endif
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave acting as an SPI mode-0 master at sclk = clk/8.
// Expected MISO words depend on whether SPI_SLAVE_MISO_EN is defined.
module tb_spi_slave;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  int errors;
  int checks;
  int vcnt;
  int ecnt;

  logic [7:0] mw;
  logic [7:0] mw2;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling clk edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) vcnt++;
    if (rx_err === 1'b1) ecnt++;
  end

  function automatic logic [7:0] exp_tx(input logic [7:0] w);
`ifdef SPI_SLAVE_MISO_EN
    return w;
`else
    return 8'h00 & w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    m = miso;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, output logic [7:0] mword);
    logic m;
    mword = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], m);
      mword = {mword[6:0], m};
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  initial begin
    logic m;
    errors  = 0;
    checks  = 0;
    vcnt    = 0;
    ecnt    = 0;
    rst     = 1'b1;
    sclk    = 1'b0;
    cs      = 1'b1;
    mosi    = 1'b0;
    tx_data = 8'h00;
    tx_load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_miso", 32'(miso), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_err", 32'(rx_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // sclk toggling with cs high must be ignored
    for (int i = 0; i < 10; i++) begin
      repeat (4) @(negedge clk);
      sclk = ~sclk;
    end
    repeat (6) @(negedge clk);
    check("idle_sclk_no_valid", 32'(vcnt), 32'd0);
    check("idle_sclk_miso", 32'(miso), 32'h0);
    check("idle_sclk_busy", 32'(busy), 32'h0);

    // Single frame
    load(8'h5A);
    cs_low();
    check("single_busy_high", 32'(busy), 32'h1);
    send_frame(8'hA5, mw);
    cs_high();
    check("single_valid_count", 32'(vcnt), 32'd1);
    check("single_rx_data", 32'(rx_data), 32'hA5);
    check("single_miso_word", 32'(mw), 32'(exp_tx(8'h5A)));
    check("single_busy_low", 32'(busy), 32'h0);
    check("single_no_err", 32'(ecnt), 32'd0);

    // Back-to-back frames, new response loaded mid first frame
    cs_low();
    mw = 8'h00;
    for (int i = 7; i >= 4; i--) begin
      send_bit(1'(8'hA5 >> i), m);
      mw = {mw[6:0], m};
    end
    load(8'hC3);
    for (int i = 3; i >= 0; i--) begin
      send_bit(1'(8'hA5 >> i), m);
      mw = {mw[6:0], m};
    end
    check("b2b_first_rx_data", 32'(rx_data), 32'hA5);
    send_frame(8'h3C, mw2);
    cs_high();
    check("b2b_valid_count", 32'(vcnt), 32'd3);
    check("b2b_second_rx_data", 32'(rx_data), 32'h3C);
    check("b2b_first_miso", 32'(mw), 32'(exp_tx(8'h5A)));
    check("b2b_second_miso", 32'(mw2), 32'(exp_tx(8'hC3)));

    // Abort after 5 bits
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1, m);
    cs_high();
    check("abort_err_count", 32'(ecnt), 32'd1);
    check("abort_no_valid", 32'(vcnt), 32'd3);
    check("abort_rx_data_held", 32'(rx_data), 32'h3C);
    check("abort_miso_idle", 32'(miso), 32'h0);
    cs_low();
    send_frame(8'h3C, mw);
    cs_high();
    check("after_abort_valid", 32'(vcnt), 32'd4);
    check("after_abort_rx_data", 32'(rx_data), 32'h3C);

    // Reset mid-frame after 3 bits
    cs_low();
    for (int i = 0; i < 3; i++) send_bit(1'b1, m);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_miso", 32'(miso), 32'h0);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    check("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check("midrst_rx_err", 32'(rx_err), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    cs  = 1'b1;
    repeat (8) @(negedge clk);
    cs_low();
    send_frame(8'h81, mw);
    cs_high();
    check("post_rst_rx_data", 32'(rx_data), 32'h81);
    check("post_rst_valid", 32'(vcnt), 32'd5);
    check("post_rst_no_err", 32'(ecnt), 32'd1);
    check("post_rst_miso_cleared_buf", 32'(mw), 32'h00);

    // Two frames without reload resend the same buffered word
    load(8'h96);
    cs_low();
    send_frame(8'h0F, mw);
    cs_high();
    check("noreload1_rx_data", 32'(rx_data), 32'h0F);
    cs_low();
    send_frame(8'hF0, mw2);
    cs_high();
    check("noreload2_rx_data", 32'(rx_data), 32'hF0);
    check("noreload1_miso", 32'(mw), 32'(exp_tx(8'h96)));
    check("noreload2_miso", 32'(mw2), 32'(exp_tx(8'h96)));
    check("final_valid_count", 32'(vcnt), 32'd7);
    check("final_err_count", 32'(ecnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
